// File: rtl/wdt_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : wdt_supervisor
// Brief    : Programmable watchdog with a two-key service sequence, optional
//            service window, a PC-stall hang detector, a pre-warning IRQ and a
//            stretched reset request with sticky reset-cause bits.
// Revision : 1.0  initial release
// ============================================================================
module wdt_supervisor #(
    parameter int         PRESCALE_LOG2 = 0,
    parameter int         GRACE         = 8,
    parameter int         RST_PULSE     = 4,
    parameter int         PC_STALL      = 16,
    parameter logic [7:0] KEY1          = 8'h55,
    parameter logic [7:0] KEY2          = 8'hAA
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [7:0] i_pc,
    output logic [7:0] o_status,
    output logic       o_irq,
    output logic       o_reset
);

    localparam int c_stall_w = $clog2(PC_STALL + 1);
    localparam int c_pulse_w = $clog2(RST_PULSE + 1);

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_RUNNING  = 2'd1,
        S_WARN     = 2'd2,
        S_RESET    = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_enable;
    logic                   r_window_en;
    logic                   r_pc_stall_en;
    logic                   r_lock;
    logic [7:0]             r_timeout;
    logic [7:0]             r_window;
    logic [7:0]             r_count;
    logic                   r_key_armed;
    logic [2:0]             r_cause;        // {pc, key, timeout}
    logic                   r_irq;
    logic                   r_reset;
    logic [c_pulse_w-1:0]   r_pulse_cnt;
    logic [c_stall_w-1:0]   r_stall_cnt;
    logic [7:0]             r_prev_pc;

    logic w_ctrl_wr, w_timeout_wr, w_window_wr, w_cfg_ok, w_active;
    logic w_key_wr, w_is_key1, w_is_key2, w_kick_try, w_key_bad, w_win_bad, w_kick;
    logic w_pc_same, w_stall_run, w_pc_bad, w_timeout, w_viol, w_to_reset;
    logic w_disable, w_enable_load, w_pulse_done, w_tick;
    logic [2:0] w_new_cause;

    assign w_ctrl_wr    = i_wr_en && (i_wr_addr == 2'd0);
    assign w_timeout_wr = i_wr_en && (i_wr_addr == 2'd1);
    assign w_window_wr  = i_wr_en && (i_wr_addr == 2'd2);
    assign w_cfg_ok     = !r_lock;
    assign w_active     = (r_state == S_RUNNING) || (r_state == S_WARN);

    // Service keys are only meaningful while the counter is live
    assign w_key_wr   = i_wr_en && (i_wr_addr == 2'd3) && w_active;
    assign w_is_key1  = (i_wr_data == KEY1);
    assign w_is_key2  = (i_wr_data == KEY2);
    assign w_kick_try = w_key_wr && w_is_key2 && r_key_armed;
    assign w_key_bad  = w_key_wr && !w_is_key1 && !(w_is_key2 && r_key_armed);
    // A kick arriving too early (count still above WINDOW) is treated as a fault
    assign w_win_bad  = w_kick_try && r_window_en && (r_state == S_RUNNING)
                        && (r_count > r_window);
    assign w_kick     = w_kick_try && !w_win_bad;

    assign w_pc_same   = (i_pc == r_prev_pc);
    assign w_stall_run = r_pc_stall_en && w_active;
    assign w_pc_bad    = w_stall_run && w_pc_same
                         && (r_stall_cnt == c_stall_w'(PC_STALL - 1));

    // A kick in the same cycle as the final WARN tick rescues the system
    assign w_timeout   = (r_state == S_WARN) && w_tick && (r_count == 8'd0) && !w_kick;
    assign w_viol      = w_key_bad || w_win_bad || w_pc_bad;
    assign w_to_reset  = w_viol || w_timeout;
    assign w_new_cause = {w_pc_bad, (w_key_bad || w_win_bad), w_timeout};

    assign w_disable     = w_ctrl_wr && w_cfg_ok && !i_wr_data[0] && w_active;
    assign w_enable_load = (r_state == S_DISABLED) && w_ctrl_wr && w_cfg_ok && i_wr_data[0];
    assign w_pulse_done  = (r_state == S_RESET)
                           && (r_pulse_cnt == c_pulse_w'(RST_PULSE - 1));

    generate
        if (PRESCALE_LOG2 > 0) begin : g_presc
            logic [PRESCALE_LOG2-1:0] r_presc;
            logic                     w_presc_clr;
            assign w_presc_clr = w_enable_load || w_kick || w_pulse_done;
            // Free-running divider while counting; restarted on every count reload
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_presc <= '0;
                end else if (w_presc_clr) begin
                    r_presc <= '0;
                end else if (w_active) begin
                    r_presc <= r_presc + 1'b1;
                end
            end
            assign w_tick = w_active && (r_presc == '1);
        end else begin : g_no_presc
            assign w_tick = w_active;
        end
    endgenerate

    // Configuration, cause tracking, stall detector and the watchdog state machine
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_DISABLED;
            r_enable      <= 1'b0;
            r_window_en   <= 1'b0;
            r_pc_stall_en <= 1'b0;
            r_lock        <= 1'b0;
            r_timeout     <= 8'hFF;
            r_window      <= 8'hFF;
            r_count       <= 8'hFF;
            r_key_armed   <= 1'b0;
            r_cause       <= 3'b000;
            r_irq         <= 1'b0;
            r_reset       <= 1'b0;
            r_pulse_cnt   <= '0;
            r_stall_cnt   <= '0;
            r_prev_pc     <= 8'h00;
        end else begin
            if (w_ctrl_wr && w_cfg_ok) begin
                r_enable      <= i_wr_data[0];
                r_window_en   <= i_wr_data[1];
                r_pc_stall_en <= i_wr_data[2];
                r_lock        <= i_wr_data[7];
            end
            if (w_timeout_wr && w_cfg_ok) begin
                r_timeout <= i_wr_data;
            end
            if (w_window_wr && w_cfg_ok) begin
                r_window <= i_wr_data;
            end

            // Cause-clear is honoured even when locked; new causes still land
            r_cause <= ((w_ctrl_wr && i_wr_data[6]) ? 3'b000 : r_cause) | w_new_cause;

            r_prev_pc <= i_pc;
            if (w_stall_run && w_pc_same && !w_to_reset && !w_disable) begin
                r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
            end else begin
                r_stall_cnt <= '0;
            end

            case (r_state)
                S_DISABLED: begin
                    if (w_enable_load) begin
                        r_state     <= S_RUNNING;
                        r_count     <= r_timeout;
                        r_key_armed <= 1'b0;
                    end
                end
                S_RUNNING, S_WARN: begin
                    if (w_to_reset) begin
                        r_state     <= S_RESET;
                        r_reset     <= 1'b1;
                        r_pulse_cnt <= '0;
                        r_key_armed <= 1'b0;
                    end else if (w_disable) begin
                        r_state     <= S_DISABLED;
                        r_irq       <= 1'b0;
                        r_key_armed <= 1'b0;
                    end else if (w_kick) begin
                        r_state     <= S_RUNNING;
                        r_count     <= r_timeout;
                        r_irq       <= 1'b0;
                        r_key_armed <= 1'b0;
                    end else begin
                        if (w_key_wr && w_is_key1) begin
                            r_key_armed <= 1'b1;
                        end
                        if (w_tick) begin
                            if (r_count == 8'd0) begin
                                // Only RUNNING gets here; WARN expiry is w_timeout
                                r_state <= S_WARN;
                                r_irq   <= 1'b1;
                                r_count <= 8'(GRACE);
                            end else begin
                                r_count <= r_count - 8'd1;
                            end
                        end
                    end
                end
                S_RESET: begin
                    if (w_pulse_done) begin
                        r_state <= r_enable ? S_RUNNING : S_DISABLED;
                        r_reset <= 1'b0;
                        r_irq   <= 1'b0;
                        r_count <= r_timeout;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + c_pulse_w'(1);
                    end
                end
                default: r_state <= S_DISABLED;
            endcase
        end
    end

    assign o_irq    = r_irq;
    assign o_reset  = r_reset;
    assign o_status = {r_reset, r_key_armed, r_lock, r_cause, r_irq, r_enable};

endmodule
`default_nettype wire

// File: tb/tb_wdt_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdt_supervisor
// Brief    : Directed self-checking bench for wdt_supervisor
// Revision : 1.0  initial release
// ============================================================================
module tb_wdt_supervisor;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr_en;
    logic [1:0] i_wr_addr;
    logic [7:0] i_wr_data;
    logic [7:0] i_pc;
    logic [7:0] o_status;
    logic       o_irq;
    logic       o_reset;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    wdt_supervisor dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_pc      (i_pc),
        .o_status  (o_status),
        .o_irq     (o_irq),
        .o_reset   (o_reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_irq(input int bound, output int n);
        n = 0;
        while (o_irq !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rst_rise(input int bound, output int n);
        n = 0;
        while (o_reset !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        while (o_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int seen;
        i_rst     = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_addr = 2'd0;
        i_wr_data = 8'h00;
        i_pc      = 8'h3C;
        tick();
        tick();
        i_rst = 1'b0;

        check("reset_status", 32'(o_status), 32'h00);
        check("reset_irq",    32'(o_irq),    32'h0);
        check("reset_rst",    32'(o_reset),  32'h0);

        // Timeout escalation
        wr(2'd1, 8'd4);
        wr(2'd0, 8'h01);
        wait_irq(20, n);
        check("t1_irq_delay", 32'(n), 32'd5);
        wait_rst_rise(20, n);
        check("t1_rst_delay", 32'(n), 32'd9);
        check("t1_cause_to", 32'(o_status[2]), 32'h1);
        pulse_len(n);
        check("t1_pulse_len", 32'(n), 32'd4);
        check("t1_irq_clear", 32'(o_irq), 32'h0);
        wait_irq(20, n);
        check("t1_reload", 32'(n), 32'd5);

        // Valid kick in WARN
        wr(2'd3, 8'h55);
        check("t2_armed", 32'(o_status[6]), 32'h1);
        wr(2'd3, 8'hAA);
        check("t2_irq_low", 32'(o_irq), 32'h0);
        check("t2_no_rst", 32'(o_reset), 32'h0);
        check("t2_disarm", 32'(o_status[6]), 32'h0);
        wait_irq(20, n);
        check("t2_reload", 32'(n), 32'd5);
        wr(2'd0, 8'h41);
        check("t2_clr_cause", 32'(o_status[4:2]), 32'h0);
        check("t2_still_en", 32'(o_status[0]), 32'h1);

        // Bad key: KEY2 without KEY1, then KEY1 followed by garbage
        wr(2'd3, 8'hAA);
        check("t3a_rst", 32'(o_reset), 32'h1);
        check("t3a_cause", 32'(o_status[4:2]), 32'b010);
        pulse_len(n);
        check("t3a_pulse", 32'(n), 32'd4);
        wr(2'd0, 8'h41);
        check("t3_clr", 32'(o_status[3]), 32'h0);
        wr(2'd3, 8'h55);
        wr(2'd3, 8'h12);
        check("t3b_rst", 32'(o_reset), 32'h1);
        check("t3b_cause", 32'(o_status[3]), 32'h1);
        pulse_len(n);

        // Early kick against the window, then a kick exactly at the boundary
        do_reset();
        wr(2'd1, 8'd20);
        wr(2'd2, 8'd5);
        wr(2'd0, 8'h03);
        idle(7);
        wr(2'd3, 8'h55);
        wr(2'd3, 8'hAA);
        check("t4a_rst", 32'(o_reset), 32'h1);
        check("t4a_cause", 32'(o_status[4:2]), 32'b010);
        pulse_len(n);
        idle(14);
        wr(2'd3, 8'h55);
        wr(2'd3, 8'hAA);
        check("t4b_no_rst", 32'(o_reset), 32'h0);
        check("t4b_disarm", 32'(o_status[6]), 32'h0);
        wait_irq(40, n);
        check("t4b_reload", 32'(n), 32'd21);

        // PC stall detection, then a PC that keeps moving
        do_reset();
        wr(2'd0, 8'h05);
        wait_rst_rise(40, n);
        check("t5a_stall_delay", 32'(n), 32'd16);
        check("t5a_cause", 32'(o_status[4:2]), 32'b100);
        pulse_len(n);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) i_pc = i_pc ^ 8'hFF;
            tick();
            if (o_reset === 1'b1) seen++;
        end
        check("t5b_no_stall", 32'(seen), 32'd0);

        // Lock behaviour, locked cause-clear, and i_rst mid-pulse
        do_reset();
        wr(2'd0, 8'h81);
        check("t6_locked", 32'(o_status), 32'h21);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h02);
        check("t6_en_kept", 32'(o_status[0]), 32'h1);
        wr(2'd3, 8'h55);
        wr(2'd3, 8'hAA);
        wait_irq(10, n);
        check("t6_timeout_kept", 32'(n), 32'd10);
        wr(2'd3, 8'h12);
        check("t6_rst", 32'(o_reset), 32'h1);
        check("t6_cause", 32'(o_status[3]), 32'h1);
        wr(2'd0, 8'h40);
        check("t6_cause_clr", 32'(o_status[4:2]), 32'h0);
        check("t6_lock_kept", 32'(o_status[5]), 32'h1);
        check("t6_pulse_on", 32'(o_reset), 32'h1);
        i_rst = 1'b1;
        tick();
        check("t6_rst_drop", 32'(o_reset), 32'h0);
        check("t6_status_clr", 32'(o_status), 32'h00);
        i_rst = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
